// File: rtl/swo_uart_pkg.sv
// Shared definitions for the SWO UART-mode receiver.
package swo_uart_pkg;

    localparam int unsigned DIV_W         = 16;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned MAX_DATA_BITS = 8;
    localparam int unsigned MAX_STOP_BITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } swo_state_e;

    // Data-bit count: 0 or anything above 8 means 8.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg);
        return ((cfg == 4'd0) || (cfg > 4'(MAX_DATA_BITS))) ? 4'(MAX_DATA_BITS) : cfg;
    endfunction

    // Stop-bit count: 0/1 mean one stop bit, 2/3 mean two.
    function automatic logic [1:0] clamp_stop_bits(input logic [1:0] cfg);
        return (cfg >= 2'd2) ? 2'(MAX_STOP_BITS) : 2'd1;
    endfunction

endpackage

// File: rtl/swo_sync.sv
// N-flop synchronizer for the asynchronous SWO pin; resets to the idle-high level.
module swo_sync #(
    parameter int unsigned pSTAGES = 2
) (
    input  logic trace_clk,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    logic [pSTAGES-1:0] ff;

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge trace_clk or posedge reset_i) begin
        if (reset_i) begin
            ff <= '1;
        end else begin
            ff <= {ff[pSTAGES-2:0], d};
        end
    end

    assign q = ff[pSTAGES-1];

endmodule

// File: rtl/swo_uart_rx.sv
// SWO UART-mode receiver: oversamples the synchronized pin and deframes LSB-first characters.
module swo_uart_rx
    import swo_uart_pkg::*;
#(
    parameter int unsigned pSYNC_STAGES = 2
) (
    input  logic              trace_clk,
    input  logic              reset_i,
    input  logic              swo_i,
    input  logic              I_swo_enable,
    input  logic [DIV_W-1:0]  I_swo_bitrate_div,
    input  logic [1:0]        I_uart_stop_bits,
    input  logic [3:0]        I_uart_data_bits,
    output logic [DATA_W-1:0] O_data,
    output logic              O_data_valid,
    output logic              O_framing_error,
    output logic              O_false_start,
    output logic              O_busy
);

    logic              rx;
    swo_state_e        state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  bit_cnt;
    logic [3:0]        n_q;
    logic [1:0]        s_q;
    logic [DATA_W-1:0] sr;
    logic [DIV_W-1:0]  half_m1;
    logic              bit_tick;

    swo_sync #(.pSTAGES(pSYNC_STAGES)) u_sync (
        .trace_clk (trace_clk),
        .reset_i   (reset_i),
        .d         (swo_i),
        .q         (rx)
    );

    // START is only entered when div>>1 is non-zero, so this never underflows in use.
    assign half_m1  = (div_q >> 1) - 16'd1;
    assign bit_tick = (cnt == div_q);

    // Frame FSM with counters, shift register and registered strobes.
    always_ff @(posedge trace_clk or posedge reset_i) begin
        if (reset_i) begin
            state           <= ST_IDLE;
            div_q           <= '0;
            cnt             <= '0;
            bit_cnt         <= '0;
            n_q             <= '0;
            s_q             <= '0;
            sr              <= '0;
            O_data          <= '0;
            O_data_valid    <= 1'b0;
            O_framing_error <= 1'b0;
            O_false_start   <= 1'b0;
            O_busy          <= 1'b0;
        end else begin
            O_data_valid    <= 1'b0;
            O_framing_error <= 1'b0;
            O_false_start   <= 1'b0;
            if (!I_swo_enable) begin
                state  <= ST_IDLE;
                O_busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!rx) begin
                            div_q   <= I_swo_bitrate_div;
                            n_q     <= clamp_data_bits(I_uart_data_bits);
                            s_q     <= clamp_stop_bits(I_uart_stop_bits);
                            bit_cnt <= '0;
                            cnt     <= '0;
                            O_busy  <= 1'b1;
                            // Zero mid-point offset: this detect sample is the start-bit check.
                            state   <= ((I_swo_bitrate_div >> 1) == 16'd0) ? ST_DATA : ST_START;
                        end
                    end
                    ST_START: begin
                        if (cnt == half_m1) begin
                            cnt <= '0;
                            if (rx) begin
                                O_false_start <= 1'b1;
                                O_busy        <= 1'b0;
                                state         <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_tick) begin
                            cnt <= '0;
                            sr  <= {rx, sr[DATA_W-1:1]};
                            if (bit_cnt == (16'(n_q) - 16'd1)) begin
                                bit_cnt <= '0;
                                state   <= ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 16'd1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_STOP: begin
                        if (bit_tick) begin
                            cnt <= '0;
                            if (!rx) begin
                                O_framing_error <= 1'b1;
                                state           <= ST_BREAK;
                            end else if (bit_cnt == (16'(s_q) - 16'd1)) begin
                                O_data       <= sr >> (4'd8 - n_q);
                                O_data_valid <= 1'b1;
                                O_busy       <= 1'b0;
                                state        <= ST_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 16'd1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_BREAK: begin
                        // Hold off until the line releases so a stuck-low line is not reread.
                        if (rx) begin
                            O_busy <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                    default: begin
                        O_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_swo_uart_rx.sv
// Directed self-checking bench for swo_uart_rx.
module tb_swo_uart_rx;

    logic        trace_clk = 1'b0;
    logic        reset_i;
    logic        swo_i;
    logic        I_swo_enable;
    logic [15:0] I_swo_bitrate_div;
    logic [1:0]  I_uart_stop_bits;
    logic [3:0]  I_uart_data_bits;
    logic [7:0]  O_data;
    logic        O_data_valid;
    logic        O_framing_error;
    logic        O_false_start;
    logic        O_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int fe_cnt = 0;
    int fs_cnt = 0;
    int last_valid_cyc = 0;
    int probe_cyc = -1;
    int frame_c0 = 0;
    logic probe_busy = 1'b1;
    logic [7:0] data_log [0:15];

    swo_uart_rx #(.pSYNC_STAGES(2)) dut (
        .trace_clk         (trace_clk),
        .reset_i           (reset_i),
        .swo_i             (swo_i),
        .I_swo_enable      (I_swo_enable),
        .I_swo_bitrate_div (I_swo_bitrate_div),
        .I_uart_stop_bits  (I_uart_stop_bits),
        .I_uart_data_bits  (I_uart_data_bits),
        .O_data            (O_data),
        .O_data_valid      (O_data_valid),
        .O_framing_error   (O_framing_error),
        .O_false_start     (O_false_start),
        .O_busy            (O_busy)
    );

    always #5 trace_clk = ~trace_clk;

    // Cycle index: value after edge k is k.
    always @(posedge trace_clk) cyc <= cyc + 1;

    // Strobe monitor sampled on the falling edge.
    always @(negedge trace_clk) begin
        if (O_data_valid) begin
            data_log[valid_cnt % 16] = O_data;
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (O_framing_error) fe_cnt++;
        if (O_false_start) fs_cnt++;
        if (cyc == probe_cyc) probe_busy = O_busy;
    end

    task automatic tick();
        @(posedge trace_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one NRZ frame LSB-first; the line is left at the last stop level.
    task automatic send_frame(input logic [7:0] b, input int nb, input int ns, input int div,
                              input logic stop_val);
        frame_c0 = cyc;
        swo_i = 1'b0;
        repeat (div + 1) tick();
        for (int i = 0; i < nb; i++) begin
            swo_i = b[i];
            repeat (div + 1) tick();
        end
        for (int i = 0; i < ns; i++) begin
            swo_i = stop_val;
            repeat (div + 1) tick();
        end
    endtask

    int v0, f0, s0, c0;

    initial begin
        reset_i = 1'b1;
        swo_i = 1'b1;
        I_swo_enable = 1'b0;
        I_swo_bitrate_div = 16'd7;
        I_uart_stop_bits = 2'd0;
        I_uart_data_bits = 4'd8;
        repeat (3) tick();
        chk("rst_data", 32'(O_data), 32'h0);
        chk("rst_strobes", {29'd0, O_data_valid, O_framing_error, O_false_start}, 32'h0);
        chk("rst_busy", 32'(O_busy), 32'h0);
        reset_i = 1'b0;
        repeat (2) tick();
        I_swo_enable = 1'b1;
        repeat (3) tick();

        // div=7, 8N1, 0xA5: valid exactly at start+78, busy low at start+79
        probe_cyc = cyc + 79;
        send_frame(8'hA5, 8, 1, 7, 1'b1);
        swo_i = 1'b1;
        c0 = frame_c0;
        repeat (6) tick();
        chk("t1_count", 32'(valid_cnt), 32'd1);
        chk("t1_data", 32'(O_data), 32'hA5);
        chk("t1_cycle", 32'(last_valid_cyc - c0), 32'd78);
        chk("t1_busy79", 32'(probe_busy), 32'h0);

        // div=3, 7 data, 2 stop, back-to-back 0x41 / 0x7F
        I_swo_bitrate_div = 16'd3;
        I_uart_data_bits = 4'd7;
        I_uart_stop_bits = 2'd2;
        v0 = valid_cnt; s0 = fs_cnt;
        send_frame(8'h41, 7, 2, 3, 1'b1);
        send_frame(8'h7F, 7, 2, 3, 1'b1);
        swo_i = 1'b1;
        repeat (10) tick();
        chk("t2_count", 32'(valid_cnt - v0), 32'd2);
        chk("t2_first", 32'(data_log[v0 % 16]), 32'h41);
        chk("t2_second", 32'(data_log[(v0 + 1) % 16]), 32'h7F);
        chk("t2_false_start", 32'(fs_cnt - s0), 32'd0);

        // div=7, 8N1, stop low, line held low 40 more cycles
        I_swo_bitrate_div = 16'd7;
        I_uart_data_bits = 4'd8;
        I_uart_stop_bits = 2'd1;
        v0 = valid_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 8, 1, 7, 1'b0);
        repeat (40) tick();
        chk("t3_fe", 32'(fe_cnt - f0), 32'd1);
        chk("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("t3_busy_break", 32'(O_busy), 32'h1);
        swo_i = 1'b1;
        repeat (6) tick();
        chk("t3_busy_idle", 32'(O_busy), 32'h0);
        chk("t3_fe_once", 32'(fe_cnt - f0), 32'd1);

        // div=15, one-cycle glitch low
        I_swo_bitrate_div = 16'd15;
        v0 = valid_cnt; s0 = fs_cnt;
        swo_i = 1'b0;
        tick();
        swo_i = 1'b1;
        repeat (30) tick();
        chk("t4_fs", 32'(fs_cnt - s0), 32'd1);
        chk("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("t4_busy", 32'(O_busy), 32'h0);

        // disable at data bit 4
        I_swo_bitrate_div = 16'd7;
        v0 = valid_cnt; f0 = fe_cnt; s0 = fs_cnt;
        swo_i = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            swo_i = 1'b1;
            repeat (8) tick();
        end
        swo_i = 1'b0;
        repeat (3) tick();
        chk("t5_busy_before", 32'(O_busy), 32'h1);
        I_swo_enable = 1'b0;
        tick();
        chk("t5_busy_after", 32'(O_busy), 32'h0);
        swo_i = 1'b1;
        repeat (5) tick();
        I_swo_enable = 1'b1;
        repeat (80) tick();
        chk("t5_no_strobes", 32'((valid_cnt - v0) + (fe_cnt - f0) + (fs_cnt - s0)), 32'd0);

        // async reset mid-frame
        chk("t5b_data_pre", 32'(O_data), 32'h7F);
        swo_i = 1'b0;
        repeat (20) tick();
        chk("t5b_busy_pre", 32'(O_busy), 32'h1);
        #3;
        reset_i = 1'b1;
        #1;
        chk("t5b_data_rst", 32'(O_data), 32'h0);
        chk("t5b_busy_rst", 32'(O_busy), 32'h0);
        chk("t5b_strobes_rst", {29'd0, O_data_valid, O_framing_error, O_false_start}, 32'h0);
        swo_i = 1'b1;
        tick();
        reset_i = 1'b0;
        repeat (5) tick();

        // div=0, 5 data bits 0x15, then data bits 0 (=8) with 0xC3
        I_swo_bitrate_div = 16'd0;
        I_uart_data_bits = 4'd5;
        I_uart_stop_bits = 2'd0;
        v0 = valid_cnt;
        send_frame(8'h15, 5, 1, 0, 1'b1);
        swo_i = 1'b1;
        c0 = frame_c0;
        repeat (6) tick();
        chk("t6_count5", 32'(valid_cnt - v0), 32'd1);
        chk("t6_data5", 32'(O_data), 32'h15);
        chk("t6_cycle5", 32'(last_valid_cyc - c0), 32'd9);
        I_uart_data_bits = 4'd0;
        v0 = valid_cnt;
        send_frame(8'hC3, 8, 1, 0, 1'b1);
        swo_i = 1'b1;
        repeat (6) tick();
        chk("t6_count8", 32'(valid_cnt - v0), 32'd1);
        chk("t6_data8", 32'(O_data), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/swo_uart_rx.md
# swo_uart_rx

SWO (Serial Wire Output) UART-mode receiver that sits directly downstream of the trace register block. It consumes that block's SWO enable, bit-rate divisor, stop-bit and data-bit settings. It oversamples the raw target SWO pin, deframes NRZ UART characters LSB-first, and emits one byte per valid frame to the trace capture path. Framing errors and false starts are flagged rather than silently dropped.

## Interface
Parameters:
- pSYNC_STAGES, 2, number of synchronizer flops on the raw SWO input (min 2)

Ports:
- trace_clk  in  1  sampling clock; the only clock
- reset_i  in  1  reset; asynchronous and active-high, one clock
- swo_i  in  1  raw SWO pin, asynchronous to trace_clk, idle high
- I_swo_enable  in  1  receiver enable
- I_swo_bitrate_div  in  16  bit period = I_swo_bitrate_div+1 trace_clk cycles
- I_uart_stop_bits  in  2  stop bits; 0→1, 3→2
- I_uart_data_bits  in  4  data bits; 0 or >8 → 8
- O_data  out  8  received character, right-justified, upper bits zero
- O_data_valid  out  1  single-cycle strobe qualifying O_data
- O_framing_error  out  1  single-cycle strobe: stop bit sampled low
- O_false_start  out  1  single-cycle strobe: start bit sampled high at mid-point
- O_busy  out  1  high in any state other than IDLE

## Operation
- Input path: swo_i passes through pSYNC_STAGES flops; all logic uses the synchronized value `rx`.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: when I_swo_enable=1 and `rx`=0, latch the divisor, the clamped data-bit count n (1–8) and the clamped stop-bit count s (1–2), clear the bit counter, and go to START. While disabled, stay in IDLE.
- START: count to div>>1 (mid-bit).
  - `rx`=1 → pulse O_false_start, go to IDLE.
  - `rx`=0 → go to DATA.
- DATA: every div+1 cycles, sample `rx` into the shift register (shift right, new bit into [7]). After n samples, go to STOP.
- STOP: every div+1 cycles, sample `rx`.
  - Any sample =0 → pulse O_framing_error, go to BREAK; no data output.
  - After s samples all =1 → O_data = shift register >> (8−n); pulse O_data_valid; go to IDLE.
- BREAK: wait for `rx`=1, then go to IDLE. This prevents a held-low line from being reread as start bits.
- Disable: I_swo_enable falling in any state → IDLE on the next edge. No strobes for the aborted frame.
- Configuration changes mid-frame have no effect until the next start detect.
- Divisor 0: bit period of 1 cycle, mid-point offset 0. Behaviour must remain correct, and the bench checks it.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer flops 1 (idle line).
- Start detect: cycle T, which is pSYNC_STAGES cycles after swo_i falls.
- First mid-point sample at T + (div>>1). Each later sample is div+1 cycles after the previous one.
- O_data_valid / O_framing_error: asserted the cycle after the deciding stop sample.
  - Valid frame: T + (div>>1) + (n+s)·(div+1) + 1.
- O_false_start: asserted the cycle after the start mid-point sample.
- O_data holds its value until the next O_data_valid.
- Back-to-back frames: the start bit is detectable on the cycle the FSM re-enters IDLE. No dead cycles beyond the one-cycle output strobe.
- Bit and period counters are 16 bits; the period counter resets to 0 on each sample, so there is no wraparound.

## Structure
- Shared package `swo_uart_pkg`: state encoding (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4) and clamp constants (max data bits 8, max stop bits 2).
- One sub-module `swo_sync`: parameterized N-flop synchronizer with a reset value of 1. Frame FSM, counters and shift register stay in the top level.

## Test plan
- div=7, 8N1, byte 0xA5, swo_i falls at cycle 0 → O_data=0xA5 and O_data_valid high exactly at cycle 2+3+9·8+1=78; O_busy low at cycle 79.
- div=3, 7 data bits, 2 stop bits, char 0x41 followed by 0x7F back-to-back → two valid strobes with O_data=0x41 then 0x7F, and zero false starts.
- div=7, 8N1, stop bit driven low, line then held low for 40 cycles → one O_framing_error pulse, no O_data_valid, O_busy high until the line returns high, then IDLE.
- div=15, 1-cycle low glitch on swo_i → O_false_start pulse once, no data.
- Frame in progress at bit 4, I_swo_enable deasserted → IDLE on the next cycle, no strobes. Also check that reset_i asserted asynchronously mid-frame zeros all outputs immediately.
- div=0, 5 data bits (I_uart_data_bits=5), char 0x15 → O_data=0x15 valid; repeat with I_uart_data_bits=0 and byte 0xC3 → O_data=0xC3.
